pipeline_skid_stage: RTL and testbench
======================================

// Module: pipeline_skid_stage
// PURPOSE
//  Generic pipeline boundary register with valid/ready flow control.
//  It replaces per-field fixed stall-driven registers between CPU stages (ID/EX, EX/MEM, MEM/WB).
//  Carries one packed payload of WIDTH bits, supports a synchronous flush and reports its occupancy.
//  With SKID=1, in_ready is registered, so backpressure timing paths are cut at each stage boundary.
// PARAMETERS
//  WIDTH           32  payload width in bits (>=1); stages pack their fields into one vector
//  SKID            1   1: two-entry skid buffer, in_ready is registered; 0: single register, in_ready combinational
//  CLEAR_ON_FLUSH  1   1: payload regs zeroed on flush; 0: payload regs hold, only valids cleared
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous squash of all held entries (branch/exception)
//  in_valid   in   1      upstream has a payload
//  in_ready   out  1      stage can accept; transfer when in_valid&in_ready (in_fire)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      main entry holds a payload
//  out_ready  in   1      downstream accepts; transfer when out_valid&out_ready (out_fire)
//  out_data   out  WIDTH  main entry payload
//  occupancy  out  2      entries held: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset (async): main_v=skid_v=0, main/skid data=0, out_valid=0, occupancy=0.
//    in_ready=1 when SKID=1 (registered); in_ready=1 when SKID=0 (main empty).
//  - Latency: in_fire in cycle N -> out_valid=1 with that data in cycle N+1. Throughput is 1 per cycle.
//  - out_valid=main_v and out_data=main data, both straight from flops. occupancy=main_v+skid_v.
//  - SKID=1 states: EMPTY(0 entries), ONE(main), FULL(main+skid). in_ready=!skid_v.
//      EMPTY: in_fire -> ONE, main<=in_data.
//      ONE:   in_fire&out_fire -> ONE, main<=in_data.
//             in_fire&!out_fire -> FULL, skid<=in_data.
//             !in_fire&out_fire -> EMPTY.
//      FULL:  in_ready=0. out_fire -> ONE, main<=skid.
//  - SKID=0 states: EMPTY, ONE. in_ready=!main_v|out_ready (combinational from out_ready).
//    in_fire loads main. out_fire without in_fire -> EMPTY.
//  - Order is preserved: skid data never bypasses main data.
//  - Payload flops load only on the transitions above; otherwise they hold. Invalid payload contents are don't-care.
//  - flush=1 (sync, highest priority): next cycle main_v=skid_v=0, occupancy=0, in_ready=1.
//      An in_fire in the flush cycle is dropped.
//      An out_fire in the flush cycle is still a completed transfer; downstream owns that beat.
//      CLEAR_ON_FLUSH=1 zeroes both payload regs; CLEAR_ON_FLUSH=0 leaves them unchanged.
//  - Reset asserted mid-transfer overrides everything: all entries are lost and outputs take reset values immediately.
//  - Both entries valid with out_ready=0 holds indefinitely. No overflow is possible because in_ready=0.
//  - WIDTH=1 is legal; no arithmetic on the payload.
// TESTING
//  1. Reset, then stream 0x1..0x8 with out_ready=1 held
//     -> out_data 0x1..0x8 on consecutive cycles, 1 cycle after each in_fire; occupancy stays 1.
//  2. SKID=1, send 0xA then 0xB with out_ready=0
//     -> occupancy=2, in_ready=0. Raise out_ready -> 0xA then 0xB, in order.
//  3. SKID=0, main holds 0xC, out_ready=0
//     -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> 0xC leaves and the new beat loads; in_ready=1 combinationally.
//  4. FULL state with flush=1 and in_valid=1 (0xD)
//     -> next cycle occupancy=0, out_valid=0, 0xD never appears.
//     CLEAR_ON_FLUSH=1: internal payload regs=0.
//  5. Flush coincident with out_fire of 0xE
//     -> 0xE counted delivered exactly once; nothing further is emitted.
//  6. Assert rst asynchronously mid-stream (between clock edges)
//     -> out_valid=0 and occupancy=0 before the next edge. After release, the first new beat emerges 1 cycle after its in_fire.

Source files
------------

// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready handshake bundle for a pipeline stage boundary: upstream
// (in_*) and downstream (out_*) sides of one stage register.
interface pipeline_skid_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // master: the environment around the stage (producer + consumer)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // slave: the stage register itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipeline_skid_stage.sv
// Pipeline boundary register with valid/ready flow control, optional
// two-entry skid buffer (registered in_ready), synchronous flush and occupancy.
module pipeline_skid_stage #(
    parameter int WIDTH          = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipeline_skid_stage_if.slave  bus,
    output logic [1:0]            occupancy
);

    // Encoding chosen so bit0 is the main valid and bit1 the skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, main_data_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             main_v, skid_v;
    logic             in_ready_int;
    logic             in_fire, out_fire;

    assign main_v   = state_reg[0];
    assign skid_v   = state_reg[1];
    assign in_fire  = bus.in_valid & in_ready_int;
    assign out_fire = main_v & bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            // Ready is a flop: it only drops when the next state has both entries.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            assign in_ready_int = in_ready_reg;
        end else begin : g_noskid
            assign in_ready_int = !main_v || bus.out_ready;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            state_next = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next     = ST_ONE;
                        main_data_next = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && (out_fire || SKID == 0)) begin
                        main_data_next = bus.in_data;
                    end else if (in_fire) begin
                        state_next     = ST_FULL;
                        skid_data_next = bus.in_data;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Skid always drains into main so order is preserved.
                    if (out_fire) begin
                        state_next     = ST_ONE;
                        main_data_next = skid_data_reg;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_data_reg;
    assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage: a skid instance (SKID=1, CLEAR_ON_FLUSH=1) and a
// plain register instance (SKID=0, CLEAR_ON_FLUSH=0) against a queue-based model.
module tb_pipeline_skid_stage;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_s, flush_r;
    logic [1:0] occ_s, occ_r;
    int         n_pass = 0;
    int         n_total = 0;

    pipeline_skid_stage_if #(.WIDTH(W)) s_if ();
    pipeline_skid_stage_if #(.WIDTH(W)) r_if ();

    pipeline_skid_stage #(.WIDTH(W), .SKID(1), .CLEAR_ON_FLUSH(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush_s), .bus(s_if), .occupancy(occ_s)
    );
    pipeline_skid_stage #(.WIDTH(W), .SKID(0), .CLEAR_ON_FLUSH(0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush_r), .bus(r_if), .occupancy(occ_r)
    );

    always #5 clk = ~clk;

    // Reference model: each stage is a FIFO of held beats, capacity 2 or 1.
    logic [W-1:0] q_s[$];
    logic [W-1:0] q_r[$];
    logic [W-1:0] obs_s[$];
    logic [W-1:0] obs_r[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s.delete();
            q_r.delete();
        end else begin : model_step
            bit of_s, if_s, of_r, if_r;
            of_s = s_if.out_ready && (q_s.size() > 0);
            if_s = s_if.in_valid && (q_s.size() < 2);
            of_r = r_if.out_ready && (q_r.size() > 0);
            if_r = r_if.in_valid && ((q_r.size() == 0) || r_if.out_ready);
            if (flush_s) q_s.delete();
            else begin
                if (of_s) void'(q_s.pop_front());
                if (if_s) q_s.push_back(s_if.in_data);
            end
            if (flush_r) q_r.delete();
            else begin
                if (of_r) void'(q_r.pop_front());
                if (if_r) q_r.push_back(r_if.in_data);
            end
        end
    end

    // Beats actually handed downstream, as seen at the DUT outputs.
    always @(negedge clk) begin
        if (!rst && s_if.out_valid && s_if.out_ready) obs_s.push_back(s_if.out_data);
        if (!rst && r_if.out_valid && r_if.out_ready) obs_r.push_back(r_if.out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
        r_if.in_valid = 1'b0; r_if.in_data = '0; r_if.out_ready = 1'b0;
        flush_s = 1'b0; flush_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({s_if.out_valid, occ_s, s_if.in_ready} !== 4'b0001) begin
            $display("FAIL reset_skid: got v/occ/rdy=%b exp 0001", {s_if.out_valid, occ_s, s_if.in_ready});
        end else n_pass++;
        n_total++;
        if ({r_if.out_valid, occ_r, r_if.in_ready} !== 4'b0001) begin
            $display("FAIL reset_reg: got v/occ/rdy=%b exp 0001", {r_if.out_valid, occ_r, r_if.in_ready});
        end else n_pass++;
        n_total++;
        if ({u_skid.main_data_reg, u_skid.skid_data_reg} !== '0) begin
            $display("FAIL reset_payload: got main=%h skid=%h exp 0/0", u_skid.main_data_reg, u_skid.skid_data_reg);
        end else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 10; k++) begin
            tick();
            s_if.in_valid = (k <= 8); s_if.in_data = W'(k); s_if.out_ready = 1'b1;
            r_if.in_valid = (k <= 8); r_if.in_data = W'(k); r_if.out_ready = 1'b1;
            @(negedge clk);
            if (k >= 2 && k <= 9) begin
                n_total++;
                if ({s_if.out_valid, s_if.out_data, occ_s} !== {1'b1, W'(k - 1), 2'd1}) begin
                    $display("FAIL stream_skid[%0d]: got v=%b d=%h occ=%0d exp v=1 d=%h occ=1",
                             k, s_if.out_valid, s_if.out_data, occ_s, W'(k - 1));
                end else n_pass++;
                n_total++;
                if ({r_if.out_valid, r_if.out_data, occ_r} !== {1'b1, W'(k - 1), 2'd1}) begin
                    $display("FAIL stream_reg[%0d]: got v=%b d=%h occ=%0d exp v=1 d=%h occ=1",
                             k, r_if.out_valid, r_if.out_data, occ_r, W'(k - 1));
                end else n_pass++;
            end
        end
        n_total++;
        if ({occ_s, occ_r} !== 4'b0000) begin
            $display("FAIL stream_drain: got occ_s=%0d occ_r=%0d exp 0/0", occ_s, occ_r);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_skid_fill();
        int mark;
        tick(); s_if.in_valid = 1'b1; s_if.in_data = 16'h000A; s_if.out_ready = 1'b0;
        tick(); s_if.in_data = 16'h000B;
        tick(); s_if.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if ({occ_s, s_if.in_ready, s_if.out_data} !== {2'd2, 1'b0, 16'h000A}) begin
                $display("FAIL skid_full_hold[%0d]: got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=000a",
                         c, occ_s, s_if.in_ready, s_if.out_data);
            end else n_pass++;
            tick();
        end
        mark = obs_s.size();
        s_if.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_total++;
        if (obs_s.size() != mark + 2 || obs_s[mark] !== 16'h000A || obs_s[mark + 1] !== 16'h000B) begin
            $display("FAIL skid_order: got %0d beats first=%h exp 2 beats 000a,000b",
                     obs_s.size() - mark, (obs_s.size() > mark) ? obs_s[mark] : 16'hxxxx);
        end else n_pass++;
        n_total++;
        if ({occ_s, s_if.in_ready} !== 3'b001) begin
            $display("FAIL skid_empty: got occ=%0d rdy=%b exp occ=0 rdy=1", occ_s, s_if.in_ready);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_comb_ready();
        tick(); r_if.in_valid = 1'b1; r_if.in_data = 16'h000C; r_if.out_ready = 1'b0;
        tick(); r_if.in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({r_if.out_valid, r_if.out_data, r_if.in_ready} !== {1'b1, 16'h000C, 1'b0}) begin
            $display("FAIL reg_stall: got v=%b d=%h rdy=%b exp v=1 d=000c rdy=0",
                     r_if.out_valid, r_if.out_data, r_if.in_ready);
        end else n_pass++;
        tick();
        r_if.in_valid = 1'b1; r_if.in_data = 16'h0005; r_if.out_ready = 1'b1;
        #1;
        n_total++;
        if (r_if.in_ready !== 1'b1) begin
            $display("FAIL reg_comb_ready: got rdy=%b exp 1", r_if.in_ready);
        end else n_pass++;
        tick(); r_if.in_valid = 1'b0; r_if.out_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({r_if.out_data, occ_r, r_if.in_ready, obs_r[$]} !== {16'h0005, 2'd1, 1'b0, 16'h000C}) begin
            $display("FAIL reg_replace: got d=%h occ=%0d rdy=%b last_out=%h exp d=0005 occ=1 rdy=0 last_out=000c",
                     r_if.out_data, occ_r, r_if.in_ready, obs_r[$]);
        end else n_pass++;
    endtask

    task automatic test_flush_full();
        int mark;
        mark = obs_s.size();
        tick(); s_if.in_valid = 1'b1; s_if.in_data = 16'h0011; s_if.out_ready = 1'b0;
        tick(); s_if.in_data = 16'h0022;
        tick(); s_if.in_data = 16'h000D; flush_s = 1'b1; flush_r = 1'b1;
        @(negedge clk);
        n_total++;
        if (occ_s !== 2'd2) begin
            $display("FAIL flush_prefull: got occ=%0d exp 2", occ_s);
        end else n_pass++;
        tick(); s_if.in_valid = 1'b0; flush_s = 1'b0; flush_r = 1'b0;
        @(negedge clk);
        n_total++;
        if ({s_if.out_valid, occ_s, s_if.in_ready} !== 4'b0001) begin
            $display("FAIL flush_skid: got v/occ/rdy=%b exp 0001", {s_if.out_valid, occ_s, s_if.in_ready});
        end else n_pass++;
        n_total++;
        if ({u_skid.main_data_reg, u_skid.skid_data_reg} !== '0) begin
            $display("FAIL flush_clear: got main=%h skid=%h exp 0/0", u_skid.main_data_reg, u_skid.skid_data_reg);
        end else n_pass++;
        n_total++;
        if ({r_if.out_valid, occ_r, u_reg.main_data_reg} !== {1'b0, 2'd0, 16'h0005}) begin
            $display("FAIL flush_hold: got v=%b occ=%0d main=%h exp v=0 occ=0 main=0005",
                     r_if.out_valid, occ_r, u_reg.main_data_reg);
        end else n_pass++;
        s_if.out_ready = 1'b1;
        repeat (4) tick();
        n_total++;
        if (obs_s.size() != mark) begin
            $display("FAIL flush_drop: got %0d beats after flush exp 0", obs_s.size() - mark);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_flush_out_fire();
        int mark;
        tick(); s_if.in_valid = 1'b1; s_if.in_data = 16'h000E; s_if.out_ready = 1'b0;
        tick(); s_if.in_valid = 1'b0;
        mark = obs_s.size();
        tick(); flush_s = 1'b1; s_if.out_ready = 1'b1;
        tick(); flush_s = 1'b0;
        repeat (4) tick();
        n_total++;
        if (obs_s.size() != mark + 1 || obs_s[mark] !== 16'h000E) begin
            $display("FAIL flush_outfire: got %0d beats first=%h exp 1 beat 000e",
                     obs_s.size() - mark, (obs_s.size() > mark) ? obs_s[mark] : 16'hxxxx);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        tick(); s_if.in_valid = 1'b1; s_if.in_data = 16'h0031; s_if.out_ready = 1'b0;
        r_if.in_valid = 1'b1; r_if.in_data = 16'h0041;
        tick(); s_if.in_data = 16'h0032; r_if.in_valid = 1'b0;
        tick(); s_if.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({s_if.out_valid, occ_s, r_if.out_valid, occ_r} !== 6'b000000) begin
            $display("FAIL async_reset: got s v/occ=%b%0d r v/occ=%b%0d exp 0/0",
                     s_if.out_valid, occ_s, r_if.out_valid, occ_r);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick(); s_if.in_valid = 1'b1; s_if.in_data = 16'h0033;
        @(negedge clk);
        n_total++;
        if ({s_if.out_valid, occ_s} !== 3'b000) begin
            $display("FAIL post_reset_wait: got v=%b occ=%0d exp v=0 occ=0", s_if.out_valid, occ_s);
        end else n_pass++;
        tick(); s_if.in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({s_if.out_valid, s_if.out_data, occ_s} !== {1'b1, 16'h0033, 2'd1}) begin
            $display("FAIL post_reset_beat: got v=%b d=%h occ=%0d exp v=1 d=0033 occ=1",
                     s_if.out_valid, s_if.out_data, occ_s);
        end else n_pass++;
        s_if.out_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick();
            s_if.in_valid  = 1'($urandom_range(0, 1));
            s_if.in_data   = W'($urandom);
            s_if.out_ready = ($urandom_range(0, 2) != 0);
            flush_s        = ($urandom_range(0, 19) == 0);
            r_if.in_valid  = 1'($urandom_range(0, 1));
            r_if.in_data   = W'($urandom);
            r_if.out_ready = ($urandom_range(0, 2) != 0);
            flush_r        = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            n_total++;
            if ({s_if.out_valid, occ_s, s_if.in_ready} !==
                {(q_s.size() != 0), 2'(q_s.size()), (q_s.size() < 2)}) begin
                $display("FAIL rand_skid_ctl[%0d]: got v/occ/rdy=%b exp held=%0d",
                         c, {s_if.out_valid, occ_s, s_if.in_ready}, q_s.size());
            end else n_pass++;
            if (q_s.size() != 0) begin
                n_total++;
                if (s_if.out_data !== q_s[0]) begin
                    $display("FAIL rand_skid_data[%0d]: got %h exp %h", c, s_if.out_data, q_s[0]);
                end else n_pass++;
            end
            n_total++;
            if ({r_if.out_valid, occ_r, r_if.in_ready} !==
                {(q_r.size() != 0), 2'(q_r.size()), ((q_r.size() == 0) || r_if.out_ready)}) begin
                $display("FAIL rand_reg_ctl[%0d]: got v/occ/rdy=%b exp held=%0d",
                         c, {r_if.out_valid, occ_r, r_if.in_ready}, q_r.size());
            end else n_pass++;
            if (q_r.size() != 0) begin
                n_total++;
                if (r_if.out_data !== q_r[0]) begin
                    $display("FAIL rand_reg_data[%0d]: got %h exp %h", c, r_if.out_data, q_r[0]);
                end else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_skid_fill();
        test_comb_ready();
        test_flush_full();
        test_flush_out_fire();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
